// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART transmit path.
//   UART_DATA_W   byte width carried between bus, FIFO and transmitter
//   HOLD_CYCLES   cycles the drain FSM waits after each issue
//   drain_state_e drain FSM encoding
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int HOLD_CYCLES = 2;
  localparam int HOLD_CNT_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } drain_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock byte FIFO, 2**DEPTH_LOG2 entries.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   push           write data_in (caller guarantees not full)
//   pop            advance read pointer (caller guarantees not empty)
//   flush          drop all contents; overrides push and pop
//   data_in        byte to write
//   data_out       byte at the read pointer (combinational from storage)
//   level          registered byte count, 0..2**DEPTH_LOG2
//   full, empty    decoded from the registered level
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [UART_DATA_W-1:0] data_in,
  output logic [UART_DATA_W-1:0] data_out,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;

  logic do_push;
  logic do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  // Storage is not reset; only pointers and level define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (flush) begin
        // Emptying by catching the read pointer up keeps the write side intact.
        rd_ptr <= wr_ptr;
        level  <= '0;
      end else begin
        if (do_pop) begin
          rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        end
        case ({do_push, do_pop})
          2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
          2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
          default: level <= level;
        endcase
      end
    end
  end

  assign data_out = mem[rd_ptr];
  assign full     = (level == DEPTH_LVL);
  assign empty    = (level == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer in front of the UART transmitter.
// Bus side pushes bytes into a FIFO; a drain FSM hands them one at a time
// to the transmitter through its write/empty handshake.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_wr, i_data          bus write strobe and byte
//   i_flush               discard all buffered bytes
//   i_ovf_clr             clear sticky overflow
//   o_full, o_empty       FIFO fill flags
//   o_level               FIFO byte count
//   o_ovf                 sticky: a write was dropped while full
//   o_idle                nothing buffered, nothing in flight, FSM idle
//   i_txe, i_txc          transmitter empty flag and byte-complete strobe
//   o_tx_wr, o_tx_data    one-cycle write strobe and byte to the transmitter
//
// state | meaning
// IDLE  | waiting for a buffered byte and i_txe; issues on that cycle
// HOLD  | blind window while the transmitter's empty flag falls
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wr,
  input  logic [UART_DATA_W-1:0] i_data,
  input  logic                   i_flush,
  input  logic                   i_ovf_clr,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [DEPTH_LOG2:0]    o_level,
  output logic                   o_ovf,
  output logic                   o_idle,
  input  logic                   i_txe,
  input  logic                   i_txc,
  output logic                   o_tx_wr,
  output logic [UART_DATA_W-1:0] o_tx_data
);

  drain_state_e           state;
  drain_state_e           state_nxt;
  logic [HOLD_CNT_W-1:0]  hold_cnt;
  logic [HOLD_CNT_W-1:0]  hold_cnt_nxt;
  logic                   push;
  logic                   pop;
  logic                   inflight;
  logic [UART_DATA_W-1:0] fifo_dout;

  // Full is the registered flag, so a pop in the same cycle cannot make room.
  assign push = i_wr & ~o_full & ~i_flush;

  uart_sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .push    (push),
    .pop     (pop),
    .flush   (i_flush),
    .data_in (i_data),
    .data_out(fifo_dout),
    .level   (o_level),
    .full    (o_full),
    .empty   (o_empty)
  );

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    pop          = 1'b0;
    if (state == ST_IDLE) begin
      // A flush in the same cycle wins over issuing the head byte.
      if (~o_empty & i_txe & ~i_flush) begin
        pop          = 1'b1;
        state_nxt    = ST_HOLD;
        hold_cnt_nxt = HOLD_CNT_W'(HOLD_CYCLES - 1);
      end
    end else begin
      if (hold_cnt == '0) begin
        state_nxt = ST_IDLE;
      end else begin
        hold_cnt_nxt = hold_cnt - HOLD_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      o_tx_wr   <= 1'b0;
      o_tx_data <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      o_tx_wr  <= pop;
      if (pop) begin
        o_tx_data <= fifo_dout;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      if (o_tx_wr) begin
        inflight <= 1'b1;
      end else if (i_txc) begin
        inflight <= 1'b0;
      end
      if (i_wr & o_full & ~i_flush) begin
        o_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
        o_ovf <= 1'b0;
      end
    end
  end

  assign o_idle = o_empty & ~inflight & (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed, self-checking bench for uart_tx_fifo.
// A cycle table covers the basic push/issue/flush behaviour; hand-written
// sequences cover reset, latency, pacing, overflow and pointer wrap, with a
// small transmitter model that drops i_txe after each strobe.
module tb_uart_tx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_wr;
  logic [7:0] i_data;
  logic       i_flush;
  logic       i_ovf_clr;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_level;
  logic       o_ovf;
  logic       o_idle;
  logic       i_txe;
  logic       i_txc;
  logic       o_tx_wr;
  logic [7:0] o_tx_data;

  logic d_txe, d_txc;
  logic m_txe = 1'b1, m_txc = 1'b0;
  logic model_en = 1'b0;
  logic rand_busy = 1'b0;
  int   m_busy = 0;
  int   cyc = 0;

  logic [7:0] rx_q[$];
  bit         rx_ok[$];
  int         rx_cyc[$];

  int checks = 0;
  int errors = 0;

  assign i_txe = model_en ? m_txe : d_txe;
  assign i_txc = model_en ? m_txc : d_txc;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr     (i_wr),
    .i_data   (i_data),
    .i_flush  (i_flush),
    .i_ovf_clr(i_ovf_clr),
    .o_full   (o_full),
    .o_empty  (o_empty),
    .o_level  (o_level),
    .o_ovf    (o_ovf),
    .o_idle   (o_idle),
    .i_txe    (i_txe),
    .i_txc    (i_txc),
    .o_tx_wr  (o_tx_wr),
    .o_tx_data(o_tx_data)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Transmitter model: accepts a strobe only while empty, then stays busy.
  always @(negedge i_clk) begin
    if (!model_en) begin
      m_txe  = 1'b1;
      m_txc  = 1'b0;
      m_busy = 0;
    end else begin
      m_txc = 1'b0;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          m_txe = 1'b1;
          m_txc = 1'b1;
        end
      end
      if (o_tx_wr) begin
        rx_q.push_back(o_tx_data);
        rx_ok.push_back(m_txe);
        rx_cyc.push_back(cyc);
        m_txe  = 1'b0;
        m_busy = rand_busy ? int'($urandom_range(1, 6)) : 80;
      end
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       flush;
    logic       clr;
    logic       txe;
    logic       txc;
    logic [4:0] level;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic       idle;
  } vec_t;

  vec_t vt[12];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    model_en  = 1'b0;
    rand_busy = 1'b0;
    i_wr      = 1'b0;
    i_data    = 8'h00;
    i_flush   = 1'b0;
    i_ovf_clr = 1'b0;
    d_txe     = 1'b0;
    d_txc     = 1'b0;
    i_rst     = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] b);
    i_wr   = 1'b1;
    i_data = b;
    tick();
    i_wr   = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    int pushed;
    int max_lvl;
    logic [7:0] exp_q[$];

    //          wr  data   fl  clr txe txc  lvl  emp ful ovf twr tdata  idle
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0};
    vt[7]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1};
    vt[10] = '{1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0};

    // Reset values
    do_reset();
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_full", 32'(o_full), 32'd0);
    chk("rst_ovf", 32'(o_ovf), 32'd0);
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_tx_wr", 32'(o_tx_wr), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'h00);

    // Cycle table
    for (int i = 0; i < 12; i++) begin
      i_wr      = vt[i].wr;
      i_data    = vt[i].data;
      i_flush   = vt[i].flush;
      i_ovf_clr = vt[i].clr;
      d_txe     = vt[i].txe;
      d_txc     = vt[i].txc;
      tick();
      chk($sformatf("vec%0d_level", i), 32'(o_level), 32'(vt[i].level));
      chk($sformatf("vec%0d_empty", i), 32'(o_empty), 32'(vt[i].empty));
      chk($sformatf("vec%0d_full", i), 32'(o_full), 32'(vt[i].full));
      chk($sformatf("vec%0d_ovf", i), 32'(o_ovf), 32'(vt[i].ovf));
      chk($sformatf("vec%0d_tx_wr", i), 32'(o_tx_wr), 32'(vt[i].tx_wr));
      chk($sformatf("vec%0d_tx_data", i), 32'(o_tx_data), 32'(vt[i].tx_data));
      chk($sformatf("vec%0d_idle", i), 32'(o_idle), 32'(vt[i].idle));
    end

    // Single byte latency and idle release on i_txc
    do_reset();
    d_txe = 1'b1;
    push_byte(8'hA5);
    chk("sb_wr_edge_n", 32'(o_tx_wr), 32'd0);
    tick();
    chk("sb_wr_edge_n1", 32'(o_tx_wr), 32'd1);
    chk("sb_data", 32'(o_tx_data), 32'hA5);
    tick();
    chk("sb_wr_one_cycle", 32'(o_tx_wr), 32'd0);
    chk("sb_data_hold", 32'(o_tx_data), 32'hA5);
    repeat (5) tick();
    chk("sb_idle_before_txc", 32'(o_idle), 32'd0);
    d_txc = 1'b1;
    tick();
    d_txc = 1'b0;
    chk("sb_idle_after_txc", 32'(o_idle), 32'd1);

    // Order and pacing with a slow transmitter
    do_reset();
    model_en = 1'b1;
    base = rx_q.size();
    for (int i = 0; i < 16; i++) push_byte(8'(i + 1));
    n = 0;
    while (((rx_q.size() - base) < 16 || !o_idle) && n < 3000) begin
      tick();
      n++;
    end
    chk("pace_timeout", 32'(n < 3000), 32'd1);
    chk("pace_count", 32'(rx_q.size() - base), 32'd16);
    for (int i = 0; i < 16 && (base + i) < rx_q.size(); i++) begin
      chk($sformatf("pace_data%0d", i), 32'(rx_q[base + i]), 32'(i + 1));
      chk($sformatf("pace_txe%0d", i), 32'(rx_ok[base + i]), 32'd1);
      if (i > 0) chk($sformatf("pace_gap%0d", i), 32'((rx_cyc[base + i] - rx_cyc[base + i - 1]) >= 3), 32'd1);
    end

    // Overflow and simultaneous events
    do_reset();
    for (int i = 0; i < 17; i++) push_byte(8'(8'h80 + i));
    chk("ovf_full", 32'(o_full), 32'd1);
    chk("ovf_level", 32'(o_level), 32'd16);
    chk("ovf_set", 32'(o_ovf), 32'd1);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    chk("ovf_clr", 32'(o_ovf), 32'd0);
    i_wr = 1'b1; i_data = 8'hAA; i_ovf_clr = 1'b1; tick(); i_wr = 1'b0; i_ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(o_ovf), 32'd1);
    chk("ovf_set_wins_level", 32'(o_level), 32'd16);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    i_wr = 1'b1; i_data = 8'hEE; d_txe = 1'b1; tick(); i_wr = 1'b0; d_txe = 1'b0;
    chk("popfull_tx_wr", 32'(o_tx_wr), 32'd1);
    chk("popfull_tx_data", 32'(o_tx_data), 32'h80);
    chk("popfull_level", 32'(o_level), 32'd15);
    chk("popfull_ovf", 32'(o_ovf), 32'd1);
    repeat (3) tick();
    push_byte(8'hEF);
    chk("refill_level", 32'(o_level), 32'd16);
    i_ovf_clr = 1'b1; tick(); i_ovf_clr = 1'b0;
    i_flush = 1'b1; i_wr = 1'b1; i_data = 8'h77; tick(); i_flush = 1'b0; i_wr = 1'b0;
    chk("flush_level", 32'(o_level), 32'd0);
    chk("flush_empty", 32'(o_empty), 32'd1);
    chk("flush_no_ovf", 32'(o_ovf), 32'd0);

    // Wrap-around with random transmitter gaps
    do_reset();
    model_en  = 1'b1;
    rand_busy = 1'b1;
    base      = rx_q.size();
    pushed    = 0;
    max_lvl   = 0;
    n         = 0;
    while (pushed < 40 && n < 4000) begin
      if (!o_full && $urandom_range(0, 1) == 1) begin
        i_wr   = 1'b1;
        i_data = 8'($urandom);
        exp_q.push_back(i_data);
        pushed++;
      end else begin
        i_wr = 1'b0;
      end
      tick();
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      n++;
    end
    i_wr = 1'b0;
    n = 0;
    while ((rx_q.size() - base) < 40 && n < 2000) begin
      tick();
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      n++;
    end
    chk("wrap_timeout", 32'(n < 2000), 32'd1);
    chk("wrap_count", 32'(rx_q.size() - base), 32'd40);
    chk("wrap_max_level", 32'(max_lvl <= 16), 32'd1);
    for (int i = 0; i < exp_q.size() && (base + i) < rx_q.size(); i++) begin
      chk($sformatf("wrap_data%0d", i), 32'(rx_q[base + i]), 32'(exp_q[i]));
    end

    // Asynchronous reset mid-drain
    do_reset();
    model_en = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
    repeat (2) tick();
    chk("mid_pre_level", 32'(o_level), 32'd4);
    #3 i_rst = 1'b1;
    #1;
    chk("mid_rst_level", 32'(o_level), 32'd0);
    chk("mid_rst_empty", 32'(o_empty), 32'd1);
    chk("mid_rst_idle", 32'(o_idle), 32'd1);
    chk("mid_rst_tx_wr", 32'(o_tx_wr), 32'd0);
    chk("mid_rst_ovf", 32'(o_ovf), 32'd0);
    do_reset();
    chk("mid_post_level", 32'(o_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
